// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: access sizes, memory
// port control codes, FSM states and the store beat planner.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [2:0] DM_RD_IDLE  = 3'b000;
    localparam logic [2:0] DM_RD_DWORD = 3'b101;

    localparam logic [2:0] DM_WR_IDLE  = 3'b000;
    localparam logic [2:0] DM_WR_BYTE  = 3'b001;
    localparam logic [2:0] DM_WR_LANE  = 3'b010;
    localparam logic [2:0] DM_WR_DWORD = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] din;
        logic [2:0]  wr;
    } dm_beat_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'd1;
            SIZE_H:  return 4'd2;
            SIZE_W:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // True when the store maps onto a single dword or 4-byte-lane write.
    function automatic logic store_is_wide(input logic [63:0] addr, input logic [1:0] size);
        return ((size == SIZE_D) && (addr[2:0] == 3'b000)) ||
               ((size == SIZE_W) && (addr[1:0] == 2'b00));
    endfunction

    function automatic logic [2:0] store_last_beat(input logic [63:0] addr, input logic [1:0] size);
        if (store_is_wide(addr, size))
            return 3'd0;
        return 3'(size_bytes(size) - 4'd1);
    endfunction

    function automatic dm_beat_t store_beat(input logic [63:0] addr, input logic [1:0] size,
                                            input logic [63:0] wdata, input logic [2:0] k);
        dm_beat_t   b;
        logic [7:0] byte_k;
        byte_k = 8'(wdata >> {k, 3'b000});
        if ((size == SIZE_D) && (addr[2:0] == 3'b000)) begin
            b.addr = addr;
            b.din  = wdata;
            b.wr   = DM_WR_DWORD;
        end else if ((size == SIZE_W) && (addr[1:0] == 2'b00)) begin
            b.addr = addr;
            b.din  = {wdata[31:0], wdata[31:0]};
            b.wr   = DM_WR_LANE;
        end else begin
            b.addr = addr + {61'b0, k};
            b.din  = {8{byte_k}};
            b.wr   = DM_WR_BYTE;
        end
        return b;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load-data extraction: picks the addressed bytes out of the
// two captured dwords and sign- or zero-extends them to 64 bits.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [63:0] lo,
    input  logic [63:0] hi,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] rdata
);

    logic [63:0] win;

    always_comb begin
        win = 64'({hi, lo} >> {offset, 3'b000});
        case (size)
            SIZE_B:  rdata = is_unsigned ? {56'b0, win[7:0]}  : {{56{win[7]}},  win[7:0]};
            SIZE_H:  rdata = is_unsigned ? {48'b0, win[15:0]} : {{48{win[15]}}, win[15:0]};
            SIZE_W:  rdata = is_unsigned ? {32'b0, win[31:0]} : {{32{win[31]}}, win[31:0]};
            default: rdata = win;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store unit front end: accepts one scalar access, splits it into data
// memory beats, assembles load data and flags out-of-window accesses.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_din,
    output logic [2:0]  dm_rd_ctrl,
    output logic [2:0]  dm_wr_ctrl,
    input  logic [63:0] dm_dout,
    output logic [2:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE. The response is
    // a single-cycle resp_valid pulse with no backpressure.

    lsu_state_e  state;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] lo_q;
    logic [63:0] hi_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        unsigned_q;
    logic        err_q;
    logic [2:0]  beat_q;
    logic [2:0]  last_beat_q;

    logic [64:0] req_end;
    logic        req_fault;
    logic        crosses;
    logic [63:0] ext_rdata;
    dm_beat_t    first_beat;
    dm_beat_t    next_beat;

    always_comb begin
        // 65-bit sum so that a wrap past 2**64 shows up as a fault too.
        req_end    = {1'b0, req_addr} + {61'b0, size_bytes(req_size)} - 65'd1;
        req_fault  = |(req_end >> MEM_ADDR_BITS);
        crosses    = ({1'b0, addr_q[2:0]} + size_bytes(size_q)) > 4'd8;
        first_beat = store_beat(req_addr, req_size, req_wdata, 3'd0);
        next_beat  = store_beat(addr_q, size_q, wdata_q, beat_q + 3'd1);
    end

    assign req_ready = (state == ST_IDLE);
    assign dbg_state = state;

    lsu_load_extract u_extract (
        .lo          (lo_q),
        .hi          (hi_q),
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rdata       (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            size_q      <= SIZE_B;
            we_q        <= 1'b0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            last_beat_q <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            dm_addr     <= '0;
            dm_din      <= '0;
            dm_rd_ctrl  <= DM_RD_IDLE;
            dm_wr_ctrl  <= DM_WR_IDLE;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        we_q        <= req_we;
                        unsigned_q  <= req_unsigned;
                        err_q       <= req_fault;
                        beat_q      <= 3'd0;
                        last_beat_q <= store_last_beat(req_addr, req_size);
                        lo_q        <= '0;
                        hi_q        <= '0;
                        if (req_fault) begin
                            state <= ST_RESP;
                        end else if (!req_we) begin
                            state      <= ST_RD0;
                            dm_addr    <= {req_addr[63:3], 3'b000};
                            dm_rd_ctrl <= DM_RD_DWORD;
                        end else begin
                            state      <= ST_WR;
                            dm_addr    <= first_beat.addr;
                            dm_din     <= first_beat.din;
                            dm_wr_ctrl <= first_beat.wr;
                        end
                    end
                end
                ST_RD0: begin
                    lo_q <= dm_dout;
                    if (crosses) begin
                        state   <= ST_RD1;
                        dm_addr <= dm_addr + 64'd8;
                    end else begin
                        state      <= ST_RESP;
                        dm_addr    <= '0;
                        dm_rd_ctrl <= DM_RD_IDLE;
                    end
                end
                ST_RD1: begin
                    hi_q       <= dm_dout;
                    state      <= ST_RESP;
                    dm_addr    <= '0;
                    dm_rd_ctrl <= DM_RD_IDLE;
                end
                ST_WR: begin
                    if (beat_q == last_beat_q) begin
                        state      <= ST_RESP;
                        dm_addr    <= '0;
                        dm_din     <= '0;
                        dm_wr_ctrl <= DM_WR_IDLE;
                    end else begin
                        beat_q     <= beat_q + 3'd1;
                        dm_addr    <= next_beat.addr;
                        dm_din     <= next_beat.din;
                        dm_wr_ctrl <= next_beat.wr;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    resp_rdata <= (err_q || we_q) ? 64'd0 : ext_rdata;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: byte-array data memory, reference model of loads,
// stores, faults and beat plans, directed cases followed by random accesses.
module tb_lsu_align;

    localparam int MAB       = 13;
    localparam int MEM_BYTES = 1 << MAB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] dm_addr;
    logic [63:0] dm_din;
    logic [2:0]  dm_rd_ctrl;
    logic [2:0]  dm_wr_ctrl;
    logic [63:0] dm_dout;
    logic [2:0]  dbg_state;

    logic [7:0]  mem     [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [63:0] exp_q[$];
    logic [63:0] wr_addr_q[$];
    logic [63:0] wr_din_q[$];
    int          rd_cnt;
    int          bad_code;
    int          n_checks;
    int          n_fail;

    lsu_align #(.MEM_ADDR_BITS(MAB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .dm_addr      (dm_addr),
        .dm_din       (dm_din),
        .dm_rd_ctrl   (dm_rd_ctrl),
        .dm_wr_ctrl   (dm_wr_ctrl),
        .dm_dout      (dm_dout),
        .dbg_state    (dbg_state)
    );

    // Clock / memory model
    always #5 clk = ~clk;

    always_comb begin
        dm_dout = '0;
        for (int i = 0; i < 8; i++)
            dm_dout[8*i +: 8] = mem[{dm_addr[MAB-1:3], 3'(i)}];
    end

    always @(negedge clk) begin
        if (dm_rd_ctrl == 3'b101)
            rd_cnt++;
        else if (dm_rd_ctrl != 3'b000)
            bad_code++;
        if (dm_wr_ctrl != 3'b000) begin
            wr_addr_q.push_back(dm_addr);
            wr_din_q.push_back(dm_din);
            case (dm_wr_ctrl)
                3'b001: mem[dm_addr[MAB-1:0]] = dm_din[8*dm_addr[2:0] +: 8];
                3'b010: for (int i = 0; i < 4; i++)
                            mem[{dm_addr[MAB-1:2], 2'(i)}] = dm_din[32*dm_addr[2] + 8*i +: 8];
                3'b100: for (int i = 0; i < 8; i++)
                            mem[{dm_addr[MAB-1:3], 3'(i)}] = dm_din[8*i +: 8];
                default: bad_code++;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int base, input logic [63:0] dw);
        for (int i = 0; i < 8; i++) begin
            mem[base + i]     = dw[8*i +: 8];
            ref_mem[base + i] = dw[8*i +: 8];
        end
    endtask

    // Reference model: whole-access semantics, byte by byte.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             output logic [63:0] obs_rdata, output logic obs_err);
        int          nb;
        logic [63:0] last;
        logic        fault;
        logic [63:0] v;
        int          exp_rd, exp_wr, exp_lat, lat, w;
        nb    = 1 << size;
        last  = addr + 64'(nb - 1);
        fault = (last < addr) || (last >= 64'(MEM_BYTES));
        v     = '0;
        exp_rd = 0;
        exp_wr = 0;
        if (!fault && !we) begin
            for (int i = 0; i < nb; i++)
                v |= 64'(ref_mem[addr[MAB-1:0] + MAB'(i)]) << (8*i);
            if (!uns && nb < 8 && v[8*nb-1])
                v |= ~64'd0 << (8*nb);
            exp_rd = ((int'(addr[2:0]) + nb) > 8) ? 2 : 1;
        end
        if (!fault && we)
            exp_wr = ((nb == 8 && addr[2:0] == 0) || (nb == 4 && addr[1:0] == 0)) ? 1 : nb;
        exp_lat = fault ? 1 : (we ? exp_wr + 1 : exp_rd + 1);
        exp_q.push_back(v);

        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 64'(req_ready), 64'd1);
        rd_cnt = 0;
        wr_addr_q.delete();
        wr_din_q.delete();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        check("resp_err", 64'(resp_err), 64'(fault));
        check("resp_rdata", resp_rdata, exp_q.pop_front());
        check("latency", 64'(lat), 64'(exp_lat));
        check("rd_beats", 64'(rd_cnt), 64'(exp_rd));
        check("wr_beats", 64'(wr_addr_q.size()), 64'(exp_wr));
        @(negedge clk);
        check("resp_pulse", 64'(resp_valid), 64'd0);
        if (!fault && we)
            for (int i = 0; i < nb; i++)
                ref_mem[addr[MAB-1:0] + MAB'(i)] = wdata[8*i +: 8];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        check({tag, "_dm_addr"}, dm_addr, 64'd0);
        check({tag, "_dm_din"}, dm_din, 64'd0);
        check({tag, "_dm_rd_ctrl"}, 64'(dm_rd_ctrl), 64'd0);
        check({tag, "_dm_wr_ctrl"}, 64'(dm_wr_ctrl), 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic        e;
        logic [63:0] a;
        logic [63:0] wd;
        int          sel;
        int          bad;

        n_checks = 0;
        n_fail   = 0;
        rd_cnt   = 0;
        bad_code = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        preload(8'h08, 64'hAABB000000000000);
        preload(8'h10, 64'h8877665544332211);

        // Reset
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;

        // Directed cases
        do_access(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, r, e);
        check("ld_aligned_lit", r, 64'h8877665544332211);
        do_access(1'b0, 2'b00, 1'b0, 64'h13, 64'd0, r, e);
        check("lb_lit", r, 64'h0000000000000044);
        do_access(1'b0, 2'b10, 1'b0, 64'h0E, 64'd0, r, e);
        check("lw_cross_lit", r, 64'h000000002211AABB);
        do_access(1'b1, 2'b00, 1'b0, 64'h13, 64'h80, r, e);
        do_access(1'b0, 2'b00, 1'b0, 64'h13, 64'd0, r, e);
        check("lb_neg_lit", r, 64'hFFFFFFFFFFFFFF80);
        do_access(1'b0, 2'b00, 1'b1, 64'h13, 64'd0, r, e);
        check("lbu_lit", r, 64'h0000000000000080);
        do_access(1'b1, 2'b01, 1'b0, 64'h21, 64'hBEEF, r, e);
        if (wr_addr_q.size() == 2) begin
            check("sh_beat0_addr", wr_addr_q[0], 64'h21);
            check("sh_beat0_din", wr_din_q[0], 64'hEFEFEFEFEFEFEFEF);
            check("sh_beat1_addr", wr_addr_q[1], 64'h22);
            check("sh_beat1_din", wr_din_q[1], 64'hBEBEBEBEBEBEBEBE);
        end
        do_access(1'b0, 2'b11, 1'b0, 64'h20, 64'd0, r, e);
        do_access(1'b1, 2'b10, 1'b0, 64'h1FFE, 64'h12345678, r, e);
        check("sw_fault_lit", 64'(e), 64'd1);
        do_access(1'b0, 2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, r, e);
        check("ld_wrap_fault_lit", 64'(e), 64'd1);

        // Reset in the middle of a misaligned dword store
        @(negedge clk);
        wr_addr_q.delete();
        wr_din_q.delete();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b11;
        req_addr  = 64'h03;
        req_wdata = 64'h0102030405060708;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_beats", 64'(wr_addr_q.size()), 64'd3);
        check_idle_outputs("rst_mid");
        for (int i = 0; i < 3; i++)
            ref_mem[3 + i] = req_wdata[8*i +: 8];
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 64'(req_ready), 64'd1);

        // Random accesses
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)
                a = {$urandom, $urandom};
            else if (sel == 1)
                a = 64'($urandom_range(MEM_BYTES - 8, MEM_BYTES - 1));
            else
                a = 64'($urandom_range(0, MEM_BYTES - 1));
            wd = {$urandom, $urandom};
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, wd, r, e);
        end

        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++)
            if (mem[i] !== ref_mem[i])
                bad++;
        check("mem_final", 64'(bad), 64'd0);
        check("ctrl_codes", 64'(bad_code), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
